// File: rtl/ibr_mode_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ibr_mode_ctrl_if
// Purpose  : Handshake bundle of ibr_mode_ctrl: input stream, output stream
//            and the start/done link to the iterative cipher core.
// Revision : 1.0
// ============================================================================
interface ibr_mode_ctrl_if #(
  parameter int BLOCK_W = 128
);
  logic               inValid;
  logic               inReady;
  logic [BLOCK_W-1:0] inData;
  logic               inLast;

  logic               coreStart;
  logic               coreDecrypt;
  logic [BLOCK_W-1:0] coreIn;
  logic               coreDone;
  logic [BLOCK_W-1:0] coreOut;

  logic               outValid;
  logic               outReady;
  logic [BLOCK_W-1:0] outData;
  logic               outLast;

  // slave is the mode controller; master is everything around it
  modport slave (
    input  inValid, inData, inLast, coreDone, coreOut, outReady,
    output inReady, coreStart, coreDecrypt, coreIn, outValid, outData, outLast
  );

  modport master (
    output inValid, inData, inLast, coreDone, coreOut, outReady,
    input  inReady, coreStart, coreDecrypt, coreIn, outValid, outData, outLast
  );
endinterface
`default_nettype wire

// File: rtl/ibr_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ibr_mode_ctrl
// Purpose  : ECB/CBC/CFB/CTR chaining around an iterative IBR cipher core.
//            CFB is compiled in only when IBR_MODE_CFB_EN is defined;
//            otherwise mode 2 behaves as ECB.
// Revision : 1.0
// ============================================================================
module ibr_mode_ctrl #(
  parameter int BLOCK_W = 128,
  parameter int IV_W    = 32,
  parameter int CTR_W   = 32
) (
  input  logic            Clk,
  input  logic            RstN,
  input  logic            clear,
  input  logic [1:0]      mode,
  input  logic            encrypt,
  input  logic [IV_W-1:0] IV,
  output logic            busy,
  ibr_mode_ctrl_if.slave  bus
);

  localparam logic [1:0] MODE_CBC = 2'd1;
`ifdef IBR_MODE_CFB_EN
  localparam logic [1:0] MODE_CFB = 2'd2;
`endif
  localparam logic [1:0] MODE_CTR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               msg_open_q, msg_open_d;
  logic [BLOCK_W-1:0] chain_q, chain_d;
  logic [1:0]         mode_q, mode_d;
  logic               enc_q, enc_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic               last_q, last_d;
  logic               drop_q, drop_d;
  logic               in_ready_q, in_ready_d;
  logic               core_start_q, core_start_d;
  logic [BLOCK_W-1:0] core_in_q, core_in_d;
  logic               core_dec_q, core_dec_d;
  logic               out_valid_q, out_valid_d;
  logic [BLOCK_W-1:0] out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               busy_q, busy_d;

  logic [BLOCK_W-1:0] iv_chain;
  logic [1:0]         mode_eff;
  logic               enc_eff;
  logic [BLOCK_W-1:0] chain_eff;
  logic [BLOCK_W-1:0] result;

  assign iv_chain = {IV, {(BLOCK_W-IV_W){1'b0}}};

  always_comb begin
    state_d      = state_q;
    msg_open_d   = msg_open_q;
    chain_d      = chain_q;
    mode_d       = mode_q;
    enc_d        = enc_q;
    data_d       = data_q;
    last_d       = last_q;
    drop_d       = drop_q;
    core_start_d = 1'b0;
    core_in_d    = core_in_q;
    core_dec_d   = core_dec_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    result       = '0;

    // mode, direction and IV are only taken from the ports on a message's first block
    mode_eff  = msg_open_q ? mode_q  : mode;
    enc_eff   = msg_open_q ? enc_q   : encrypt;
    chain_eff = msg_open_q ? chain_q : iv_chain;

    case (state_q)
      S_IDLE: begin
        if (bus.inValid) begin
          state_d      = S_START;
          data_d       = bus.inData;
          last_d       = bus.inLast;
          mode_d       = mode_eff;
          enc_d        = enc_eff;
          chain_d      = chain_eff;
          msg_open_d   = 1'b1;
          core_start_d = 1'b1;
          case (mode_eff)
            MODE_CBC: begin
              core_in_d  = enc_eff ? (bus.inData ^ chain_eff) : bus.inData;
              core_dec_d = !enc_eff;
            end
`ifdef IBR_MODE_CFB_EN
            MODE_CFB: begin
              core_in_d  = chain_eff;
              core_dec_d = 1'b0;
            end
`endif
            MODE_CTR: begin
              core_in_d  = chain_eff;
              core_dec_d = 1'b0;
            end
            default: begin
              core_in_d  = bus.inData;
              core_dec_d = !enc_eff;
            end
          endcase
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.coreDone) begin
          if (drop_q) begin
            drop_d = 1'b0;
          end else begin
            state_d     = S_OUT;
            out_valid_d = 1'b1;
            out_last_d  = last_q;
            case (mode_q)
              MODE_CBC: begin
                if (enc_q) begin
                  result  = bus.coreOut;
                  chain_d = bus.coreOut;
                end else begin
                  result  = bus.coreOut ^ chain_q;
                  chain_d = data_q;
                end
              end
`ifdef IBR_MODE_CFB_EN
              MODE_CFB: begin
                result  = bus.coreOut ^ data_q;
                chain_d = enc_q ? result : data_q;
              end
`endif
              MODE_CTR: begin
                result                = bus.coreOut ^ data_q;
                chain_d[CTR_W-1:0]    = chain_q[CTR_W-1:0] + CTR_W'(1);
              end
              default: result = bus.coreOut;
            endcase
            out_data_d = result;
          end
        end
      end
      S_OUT: begin
        if (bus.outReady) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
          if (last_q) msg_open_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      // a block already handed to the core will still report done; swallow it
      if ((state_q == S_START) ||
          ((state_q == S_WAIT) && !(bus.coreDone && !drop_q)))
        drop_d = 1'b1;
      state_d      = S_IDLE;
      msg_open_d   = 1'b0;
      chain_d      = '0;
      out_valid_d  = 1'b0;
      core_start_d = 1'b0;
    end

    in_ready_d = (state_d == S_IDLE);
    busy_d     = msg_open_d | (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q      <= S_IDLE;
      msg_open_q   <= 1'b0;
      chain_q      <= '0;
      mode_q       <= '0;
      enc_q        <= 1'b0;
      data_q       <= '0;
      last_q       <= 1'b0;
      drop_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      core_start_q <= 1'b0;
      core_in_q    <= '0;
      core_dec_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      msg_open_q   <= msg_open_d;
      chain_q      <= chain_d;
      mode_q       <= mode_d;
      enc_q        <= enc_d;
      data_q       <= data_d;
      last_q       <= last_d;
      drop_q       <= drop_d;
      in_ready_q   <= in_ready_d;
      core_start_q <= core_start_d;
      core_in_q    <= core_in_d;
      core_dec_q   <= core_dec_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.inReady     = in_ready_q;
  assign bus.coreStart   = core_start_q;
  assign bus.coreIn      = core_in_q;
  assign bus.coreDecrypt = core_dec_q;
  assign bus.outValid    = out_valid_q;
  assign bus.outData     = out_data_q;
  assign bus.outLast     = out_last_q;
  assign busy            = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ibr_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibr_mode_ctrl
// Purpose  : Directed bench for ibr_mode_ctrl with an inverting 4-cycle core.
// Revision : 1.0
// ============================================================================
module tb_ibr_mode_ctrl;
  localparam int BLOCK_W = 128;
  localparam int IV_W    = 32;
  localparam int CTR_W   = 4;

  logic            Clk = 1'b0;
  logic            RstN;
  logic            clear = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic            encrypt = 1'b1;
  logic [IV_W-1:0] IV = '0;
  logic            busy;

  int checks = 0;
  int errors = 0;

  ibr_mode_ctrl_if #(.BLOCK_W(BLOCK_W)) bus ();

  ibr_mode_ctrl #(.BLOCK_W(BLOCK_W), .IV_W(IV_W), .CTR_W(CTR_W)) dut (
    .Clk     (Clk),
    .RstN    (RstN),
    .clear   (clear),
    .mode    (mode),
    .encrypt (encrypt),
    .IV      (IV),
    .busy    (busy),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  // core model: result = ~coreIn, done four cycles after start, unaffected by RstN
  logic [3:0]         done_pipe = '0;
  logic [BLOCK_W-1:0] din_pipe [4];
  int                 start_cnt = 0;
  logic [BLOCK_W-1:0] last_core_in = '0;
  logic               last_core_dec = 1'b0;

  always @(posedge Clk) begin
    done_pipe   <= {done_pipe[2:0], bus.coreStart};
    din_pipe[0] <= bus.coreIn;
    din_pipe[1] <= din_pipe[0];
    din_pipe[2] <= din_pipe[1];
    din_pipe[3] <= din_pipe[2];
    if (bus.coreStart) begin
      start_cnt     <= start_cnt + 1;
      last_core_in  <= bus.coreIn;
      last_core_dec <= bus.coreDecrypt;
    end
  end
  assign bus.coreDone = done_pipe[3];
  assign bus.coreOut  = ~din_pipe[3];

  task automatic send_block(input logic [BLOCK_W-1:0] d, input logic l, output logic ok);
    ok = 1'b0;
    @(negedge Clk);
    bus.inValid = 1'b1;
    bus.inData  = d;
    bus.inLast  = l;
    for (int i = 0; i < 50; i++) begin
      if (bus.inReady) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    @(posedge Clk);
    #1;
    bus.inValid = 1'b0;
  endtask

  task automatic recv_block(output logic [BLOCK_W-1:0] d, output logic l,
                            output int lat, output logic ok);
    ok  = 1'b0;
    lat = 0;
    d   = '0;
    l   = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      lat++;
      if (bus.outValid) begin
        d  = bus.outData;
        l  = bus.outLast;
        ok = 1'b1;
        break;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    RstN = 1'b1;
    #2 RstN = 1'b0;
    #10;
    checks++;
    if ({bus.inReady, bus.outValid, bus.outLast, bus.coreStart, bus.coreDecrypt, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000",
               {bus.inReady, bus.outValid, bus.outLast, bus.coreStart, bus.coreDecrypt, busy});
    end
    checks++;
    if (bus.outData !== '0) begin
      errors++;
      $display("FAIL reset_outData got %h want 0", bus.outData);
    end
    checks++;
    if (bus.coreIn !== '0) begin
      errors++;
      $display("FAIL reset_coreIn got %h want 0", bus.coreIn);
    end
    @(negedge Clk);
    RstN = 1'b1;
    #1;
    checks++;
    if (bus.inReady !== 1'b0) begin
      errors++;
      $display("FAIL reset_inReady_early got %b want 0", bus.inReady);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (bus.inReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_inReady_rise got %b want 1", bus.inReady);
    end
  endtask

  task automatic test_ctr();
    logic [BLOCK_W-1:0] d;
    logic l, ok, ok2;
    int lat, s0;
    s0 = start_cnt;
    mode = 2'd3; encrypt = 1'b1; IV = 32'h1111_1111;
    send_block(128'h1234_56ab_cd13_2536_1234_56ab_cd13_2536, 1'b0, ok);
    recv_block(d, l, lat, ok2);
    checks++;
    if (!(ok && ok2)) begin
      errors++;
      $display("FAIL ctr_handshake got %b%b want 11", ok, ok2);
    end
    checks++;
    if (last_core_in !== 128'h1111_1111_0000_0000_0000_0000_0000_0000) begin
      errors++;
      $display("FAIL ctr_coreIn0 got %h want 11111111000000000000000000000000", last_core_in);
    end
    checks++;
    if (d !== 128'hFCDA_B845_32EC_DAC9_EDCB_A954_32EC_DAC9) begin
      errors++;
      $display("FAIL ctr_out0 got %h want fcdab84532ecdac9edcba95432ecdac9", d);
    end
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL ctr_latency got %0d want 6", lat);
    end
    checks++;
    if (l !== 1'b0 || last_core_dec !== 1'b0) begin
      errors++;
      $display("FAIL ctr_last_dec got %b%b want 00", l, last_core_dec);
    end
    // mid-message changes must not take effect
    mode = 2'd0; IV = 32'h9999_9999;
    send_block('0, 1'b1, ok);
    recv_block(d, l, lat, ok2);
    checks++;
    if (last_core_in !== 128'h1111_1111_0000_0000_0000_0000_0000_0001) begin
      errors++;
      $display("FAIL ctr_coreIn1 got %h want 11111111000000000000000000000001", last_core_in);
    end
    checks++;
    if (d !== 128'hEEEE_EEEE_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE || l !== 1'b1) begin
      errors++;
      $display("FAIL ctr_out1 got %h/%b want eeeeeeeefffffffffffffffffffffffe/1", d, l);
    end
    checks++;
    if (busy !== 1'b0 || start_cnt - s0 !== 2) begin
      errors++;
      $display("FAIL ctr_end got busy=%b starts=%0d want busy=0 starts=2", busy, start_cnt - s0);
    end
  endtask

  task automatic test_cbc_round_trip();
    logic [BLOCK_W-1:0] p1, p2, c1, c2, e1, e2, d;
    logic l1, l2, ok, ok2;
    int lat;
    p1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    p2 = 128'hdead_beef_0000_ffff_a5a5_5a5a_1357_9bdf;
    IV = 32'hA5A5_0F0F; mode = 2'd1; encrypt = 1'b1;
    e1 = ~(p1 ^ {32'hA5A5_0F0F, 96'h0});
    e2 = ~(p2 ^ e1);
    send_block(p1, 1'b0, ok);
    recv_block(c1, l1, lat, ok2);
    send_block(p2, 1'b1, ok);
    recv_block(c2, l2, lat, ok2);
    checks++;
    if (c1 !== e1 || c2 !== e2) begin
      errors++;
      $display("FAIL cbc_enc got %h %h want %h %h", c1, c2, e1, e2);
    end
    checks++;
    if (l1 !== 1'b0 || l2 !== 1'b1 || last_core_dec !== 1'b0) begin
      errors++;
      $display("FAIL cbc_enc_flags got %b%b%b want 010", l1, l2, last_core_dec);
    end
    encrypt = 1'b0;
    send_block(c1, 1'b0, ok);
    recv_block(d, l1, lat, ok2);
    checks++;
    if (d !== p1 || l1 !== 1'b0) begin
      errors++;
      $display("FAIL cbc_dec1 got %h/%b want %h/0", d, l1, p1);
    end
    send_block(c2, 1'b1, ok);
    recv_block(d, l2, lat, ok2);
    checks++;
    if (d !== p2 || l2 !== 1'b1 || last_core_dec !== 1'b1) begin
      errors++;
      $display("FAIL cbc_dec2 got %h/%b/%b want %h/1/1", d, l2, last_core_dec, p2);
    end
  endtask

  task automatic test_ecb_mode2();
    logic [BLOCK_W-1:0] p, d, exp_out, exp_in;
    logic l, ok, ok2, exp_dec;
    int lat;
    p = 128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0;
    mode = 2'd0; encrypt = 1'b0; IV = 32'h7777_0000;
    send_block(p, 1'b1, ok);
    recv_block(d, l, lat, ok2);
    checks++;
    if (d !== ~p || last_core_in !== p || last_core_dec !== 1'b1) begin
      errors++;
      $display("FAIL ecb_dec got %h/%h/%b want %h/%h/1", d, last_core_in, last_core_dec, ~p, p);
    end
    mode = 2'd2;
`ifdef IBR_MODE_CFB_EN
    exp_in  = {32'h7777_0000, 96'h0};
    exp_out = ~exp_in ^ p;
    exp_dec = 1'b0;
`else
    exp_in  = p;
    exp_out = ~p;
    exp_dec = 1'b1;
`endif
    send_block(p, 1'b1, ok);
    recv_block(d, l, lat, ok2);
    checks++;
    if (d !== exp_out || last_core_in !== exp_in || last_core_dec !== exp_dec) begin
      errors++;
      $display("FAIL mode2 got %h/%h/%b want %h/%h/%b",
               d, last_core_in, last_core_dec, exp_out, exp_in, exp_dec);
    end
  endtask

  task automatic test_backpressure();
    logic [BLOCK_W-1:0] p;
    logic ok, seen;
    int s0;
    p = 128'h5555_aaaa_5555_aaaa_0000_1111_2222_3333;
    mode = 2'd0; encrypt = 1'b1;
    bus.outReady = 1'b0;
    send_block(p, 1'b1, ok);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (bus.outValid) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_outValid got 0 want 1");
    end
    s0 = start_cnt;
    bus.inValid = 1'b1;
    bus.inData  = ~p;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      checks++;
      if (bus.outValid !== 1'b1 || bus.outData !== ~p || bus.inReady !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got v=%b d=%h r=%b want v=1 d=%h r=0",
                 i, bus.outValid, bus.outData, bus.inReady, ~p);
      end
    end
    checks++;
    if (start_cnt !== s0) begin
      errors++;
      $display("FAIL bp_starts got %0d want %0d", start_cnt, s0);
    end
    bus.inValid  = 1'b0;
    bus.outReady = 1'b1;
    @(posedge Clk);
    #1;
    checks++;
    if (bus.outValid !== 1'b0 || bus.inReady !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got v=%b r=%b want v=0 r=1", bus.outValid, bus.inReady);
    end
  endtask

  task automatic test_clear();
    logic [BLOCK_W-1:0] p_old, p_new, d, e;
    logic l, ok, ok2;
    int lat;
    p_old = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    p_new = 128'h0102_0304_0506_0708_090a_0b0c_0d0e_0f10;
    mode = 2'd1; encrypt = 1'b1; IV = 32'h1357_9BDF;
    send_block(p_old, 1'b0, ok);
    @(posedge Clk);
    #1;
    clear = 1'b1;
    @(posedge Clk);
    #1;
    clear = 1'b0;
    checks++;
    if (bus.inReady !== 1'b1 || bus.outValid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_idle got r=%b v=%b busy=%b want 1 0 0", bus.inReady, bus.outValid, busy);
    end
    IV = 32'h2468_ACE0;
    e  = ~(p_new ^ {32'h2468_ACE0, 96'h0});
    send_block(p_new, 1'b1, ok);
    recv_block(d, l, lat, ok2);
    checks++;
    if (d !== e || lat !== 6 || !ok2) begin
      errors++;
      $display("FAIL clear_next got %h lat=%0d want %h lat=6", d, lat, e);
    end
  endtask

  task automatic test_ctr_wrap();
    logic [BLOCK_W-1:0] d, e;
    logic l, ok, ok2;
    int lat;
    mode = 2'd3; encrypt = 1'b1; IV = 32'hCAFE_F00D;
    for (int i = 0; i < 17; i++) begin
      e      = {32'hCAFE_F00D, 96'h0};
      e[3:0] = 4'(i);
      send_block('0, (i == 16), ok);
      recv_block(d, l, lat, ok2);
      checks++;
      if (last_core_in !== e || d !== ~e) begin
        errors++;
        $display("FAIL ctr_wrap blk %0d got in=%h out=%h want in=%h out=%h",
                 i, last_core_in, d, e, ~e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic ok, bad;
    mode = 2'd0; encrypt = 1'b1;
    send_block(128'h3c3c, 1'b1, ok);
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1;
    RstN = 1'b0;
    #1;
    checks++;
    if ({bus.outValid, bus.inReady, bus.coreStart, busy} !== 4'b0 || bus.coreIn !== '0) begin
      errors++;
      $display("FAIL midreset got %b coreIn=%h want 0000 0",
               {bus.outValid, bus.inReady, bus.coreStart, busy}, bus.coreIn);
    end
    @(negedge Clk);
    RstN = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (bus.outValid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || bus.inReady !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_late_done got stray=%b r=%b busy=%b want 0 1 0", bad, bus.inReady, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [BLOCK_W-1:0] d;
    logic l, ok, ok2;
    int lat;
    mode = 2'd0; encrypt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_block(128'(i * 7 + 1), (i == 2), ok);
      recv_block(d, l, lat, ok2);
      checks++;
      if (d !== ~128'(i * 7 + 1) || l !== (i == 2) || lat !== 6) begin
        errors++;
        $display("FAIL b2b blk %0d got %h/%b lat=%0d want %h/%b lat=6",
                 i, d, l, lat, ~128'(i * 7 + 1), (i == 2));
      end
    end
  endtask

  initial begin
    bus.inValid  = 1'b0;
    bus.inData   = '0;
    bus.inLast   = 1'b0;
    bus.outReady = 1'b1;
    test_reset();
    test_ctr();
    test_cbc_round_trip();
    test_ecb_mode2();
    test_backpressure();
    test_clear();
    test_ctr_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
